one_wire_tx_sequencer: RTL
==========================

Name: one_wire_tx_sequencer

Overview:
Sequences a 1-Wire transmit burst out of the 32x8 scratchpad BRAM. The host supplies a base address and a byte count. The block optionally requests a 1-Wire reset/presence cycle first. It then fetches each byte through the BRAM read port (read_en/address, data_dv) and hands it to the 1-Wire byte engine over a valid/ready handshake. It sits between the host control registers, the BRAM read port and the byte engine.

Parameters:
ADDR_WIDTH, 5, BRAM address width (depth 2**ADDR_WIDTH = 32)
DATA_WIDTH, 8, byte width
LEN_WIDTH, 6, width of length/count fields
DV_TIMEOUT, 15, max cycles to wait for mem_rd_dv before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a burst; sampled only in IDLE
abort  in  1  terminate current burst
base_addr  in  ADDR_WIDTH  first BRAM address, captured on start
length  in  LEN_WIDTH  bytes to send, captured on start
send_reset  in  1  issue a 1-Wire reset/presence cycle before the bytes, captured on start
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on failure
err_code  out  3  1=no presence, 2=mem timeout, 3=bad length, 4=aborted; holds until next start
bytes_sent  out  LEN_WIDTH  bytes accepted by the engine in the current/last burst
mem_rd_en  out  1  BRAM read request
mem_rd_addr  out  ADDR_WIDTH  BRAM read address
mem_rd_data  in  DATA_WIDTH  BRAM read data
mem_rd_dv  in  1  BRAM read data valid (single-cycle pulse)
ow_rst_req  out  1  request 1-Wire reset/presence cycle
ow_rst_ack  in  1  reset cycle complete (pulse)
ow_presence  in  1  presence result, valid with ow_rst_ack
tx_valid  out  1  byte available to the engine
tx_data  out  DATA_WIDTH  byte to transmit
tx_ready  in  1  engine accepts byte when tx_valid and tx_ready are both high

Behaviour:
- Reset: state IDLE. busy, done, error, mem_rd_en, ow_rst_req and tx_valid are 0. err_code, bytes_sent, mem_rd_addr and tx_data are 0.
- States: IDLE, CHECK, OW_RST, RD_REQ, TX, FINISH.
- IDLE, start=1: capture base_addr, length and send_reset; clear bytes_sent and err_code; go to CHECK. In all other states start is ignored.
- CHECK: length > 2**ADDR_WIDTH -> error pulse, err_code=3, no bus or memory activity, back to IDLE. Otherwise go to OW_RST if send_reset, else RD_REQ if length != 0, else FINISH.
- OW_RST: ow_rst_req held high until ow_rst_ack is sampled, then dropped.
  - ow_presence=0 at ack -> error, err_code=1.
  - Otherwise go to RD_REQ, or to FINISH if length=0.
- RD_REQ: mem_rd_en=1 and mem_rd_addr held stable until mem_rd_dv is sampled high. On the dv cycle, latch mem_rd_data into tx_data, drop mem_rd_en next cycle, go to TX.
  - A wait counter resets on entry. If DV_TIMEOUT cycles pass without dv -> error, err_code=2.
  - mem_rd_dv is ignored in every other state.
- TX: tx_valid=1 with tx_data stable until tx_ready is sampled.
  - On handshake: bytes_sent += 1 and mem_rd_addr advances by one, modulo 2**ADDR_WIDTH (31 wraps to 0).
  - bytes_sent == length -> FINISH, else RD_REQ.
- FINISH: done pulses for one cycle; back to IDLE.
- busy is registered and high in every state except IDLE.
- Error path: error pulses for one cycle while all requests drop in the same cycle; state returns to IDLE.
- abort (any non-IDLE state): next cycle mem_rd_en, ow_rst_req and tx_valid are 0, error pulses with err_code=4, state goes to IDLE. An abort coincident with a tx handshake still counts that byte. abort in IDLE has no effect.
- reset mid-burst: immediate return to reset values; no done or error pulse.
- Throughput: at least one byte per (memory latency + 2) cycles when tx_ready is held high.

Test Plan:
- BRAM preloaded 0x10..0x13 at addr 4..7; start, base=4, len=4, send_reset=0, tx_ready=1 -> tx_data sequence 10,11,12,13; done pulse; bytes_sent=4; error never asserted.
- base=30, len=4 -> reads addr 30,31,0,1 in that order; done.
- send_reset=1, presence=0 at ack -> error, err_code=1, no mem_rd_en ever asserted; send_reset=1, presence=1, len=0 -> done right after ack.
- len=33 -> error, err_code=3 within 2 cycles of start, no outputs toggled; memory model never returns dv -> error, err_code=2 after 15 cycles.
- tx_ready held low 10 cycles on byte 2 -> tx_valid and tx_data stable throughout; start pulsed mid-burst is ignored; bytes_sent final = length.
- abort asserted during TX of byte 3 of 5 -> tx_valid drops next cycle, err_code=4, bytes_sent=2; reset mid-RD_REQ -> all outputs at reset values, no pulse.

Source files
------------

// File: rtl/one_wire_tx_sequencer.sv
// 1-Wire transmit burst sequencer: optional reset/presence cycle, then streams
// bytes from the scratchpad BRAM read port into the byte engine over valid/ready.
module one_wire_tx_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6,
  parameter int DV_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  send_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [LEN_WIDTH-1:0]  bytes_sent,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_dv,
  output logic                  ow_rst_req,
  input  logic                  ow_rst_ack,
  input  logic                  ow_presence,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WAIT_W = $clog2(DV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_OW_RST, S_RD_REQ, S_TX, S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_NO_PRES = 3'd1,
    ERR_MEM_TO  = 3'd2,
    ERR_BAD_LEN = 3'd3,
    ERR_ABORT   = 3'd4
  } err_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_busy;
  logic                  r_error;
  err_e                  r_err_code;
  logic [LEN_WIDTH-1:0]  r_bytes_sent;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_send_rst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [WAIT_W-1:0]     r_wait;

  logic                  w_fail;
  err_e                  w_fail_code;
  logic                  w_accept;
  logic                  w_dv_take;
  logic                  w_hs;
  logic [LEN_WIDTH-1:0]  w_sent_inc;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    w_accept    = (r_state == S_IDLE) && start;
    w_dv_take   = (r_state == S_RD_REQ) && mem_rd_dv;
    w_hs        = (r_state == S_TX) && tx_ready;
    w_sent_inc  = r_bytes_sent + 1'b1;

    case (r_state)
      S_IDLE:
        if (start) w_state_nxt = S_CHECK;
      S_CHECK:
        if (int'(r_len) > DEPTH) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_BAD_LEN;
        end else if (r_send_rst) begin
          w_state_nxt = S_OW_RST;
        end else begin
          w_state_nxt = (r_len != '0) ? S_RD_REQ : S_FINISH;
        end
      S_OW_RST:
        if (ow_rst_ack) begin
          if (!ow_presence) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_NO_PRES;
          end else begin
            w_state_nxt = (r_len != '0) ? S_RD_REQ : S_FINISH;
          end
        end
      S_RD_REQ:
        if (mem_rd_dv) begin
          w_state_nxt = S_TX;
        end else if (r_wait == WAIT_W'(DV_TIMEOUT - 1)) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_MEM_TO;
        end
      S_TX:
        if (tx_ready) w_state_nxt = (w_sent_inc == r_len) ? S_FINISH : S_RD_REQ;
      S_FINISH:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase

    // Abort wins over any other outcome, but a coincident handshake still counts.
    if (abort && r_state != S_IDLE) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_ABORT;
    end
    if (w_fail) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_bytes_sent <= '0;
      r_len        <= '0;
      r_send_rst   <= 1'b0;
      r_addr       <= '0;
      r_tx_data    <= '0;
      r_wait       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_error <= w_fail;
      // Cleared outside RD_REQ, so it always starts from zero on entry.
      r_wait  <= (r_state == S_RD_REQ) ? r_wait + 1'b1 : '0;
      if (w_accept) begin
        r_addr       <= base_addr;
        r_len        <= length;
        r_send_rst   <= send_reset;
        r_bytes_sent <= '0;
        r_err_code   <= ERR_NONE;
      end
      if (w_fail)    r_err_code <= w_fail_code;
      if (w_dv_take) r_tx_data  <= mem_rd_data;
      if (w_hs) begin
        r_bytes_sent <= w_sent_inc;
        r_addr       <= r_addr + 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = (r_state == S_FINISH);
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign bytes_sent  = r_bytes_sent;
  assign mem_rd_en   = (r_state == S_RD_REQ);
  assign mem_rd_addr = r_addr;
  assign ow_rst_req  = (r_state == S_OW_RST);
  assign tx_valid    = (r_state == S_TX);
  assign tx_data     = r_tx_data;

endmodule
